// File: rtl/ds_dac_multi_pkg.sv
// Shared types and constant helpers for the multi-channel delta-sigma DAC.
package ds_dac_pkg;

  typedef enum logic {
    ORDER1 = 1'b0,
    ORDER2 = 1'b1
  } order_e;

  // Channel-select width, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Magnitude both second-order integrators saturate to: 2^(WIDTH+1).
  function automatic int unsigned sat_limit(input int unsigned width);
    return 32'd1 << (width + 1);
  endfunction

endpackage

// File: rtl/ds_dac_multi_if.sv
// Write port for the per-channel shadow registers (valid/ready).
interface ds_dac_multi_if
  import ds_dac_pkg::*;
#(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned CHAN_W = clog2_min1(CHANNELS);

  logic              in_valid;
  logic              in_ready;
  logic [CHAN_W-1:0] in_chan;
  logic [WIDTH-1:0]  in_data;

  modport master (output in_valid, in_chan, in_data, input in_ready);
  modport slave  (input in_valid, in_chan, in_data, output in_ready);
endinterface

// File: rtl/ds_dac_multi_mod_core.sv
// One delta-sigma channel: 1st-order accumulator or 2nd-order CIFB loop.
module ds_mod_core
  import ds_dac_pkg::*;
#(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             clear,
  input  order_e           order,
  input  logic [WIDTH-1:0] code,
  output logic             y,
  output logic             y_step
);
  localparam int unsigned IW = WIDTH + 3;
  localparam int unsigned EW = WIDTH + 5;
  localparam logic signed [EW-1:0] HALF = EW'(2 ** (WIDTH - 1));
  localparam logic signed [EW-1:0] LIM  = EW'(sat_limit(WIDTH));

  function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] v);
    if (v > LIM)  return IW'(LIM);
    if (v < -LIM) return IW'(-LIM);
    return IW'(v);
  endfunction

  // The accumulator keeps only its low WIDTH bits; the carry bit lives in r_y.
  logic [WIDTH-1:0]     r_acc;
  logic signed [IW-1:0] r_i1;
  logic signed [IW-1:0] r_i2;
  logic                 r_y;

  logic [WIDTH-1:0]     w_acc;
  logic signed [IW-1:0] w_i1;
  logic signed [IW-1:0] w_i2;
  logic                 w_y;
  logic [WIDTH:0]       w_sum;
  logic signed [EW-1:0] w_x;
  logic signed [EW-1:0] w_fb;
  logic signed [EW-1:0] w_i1_raw;
  logic signed [EW-1:0] w_i2_raw;
  logic signed [IW-1:0] w_i1n;
  logic signed [IW-1:0] w_i2n;

  // Step arithmetic for both orders, starting from zeroed state when clear is set.
  always_comb begin
    w_acc    = clear ? '0 : r_acc;
    w_i1     = clear ? '0 : r_i1;
    w_i2     = clear ? '0 : r_i2;
    w_y      = clear ? 1'b0 : r_y;
    w_sum    = {1'b0, w_acc} + {1'b0, code};
    w_x      = signed'(EW'(code)) - HALF;
    w_fb     = w_y ? HALF : -HALF;
    w_i1_raw = EW'(w_i1) + w_x - w_fb;
    w_i2_raw = EW'(w_i2) + EW'(w_i1) - w_fb;
    w_i1n    = sat(w_i1_raw);
    w_i2n    = sat(w_i2_raw);
    if (order == ORDER2) y_step = !w_i2n[IW-1] && (w_i2n != '0);
    else                 y_step = w_sum[WIDTH];
  end

  // Modulator state advances only on sample ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_i1  <= '0;
      r_i2  <= '0;
      r_y   <= 1'b0;
    end else if (tick) begin
      if (order == ORDER2) begin
        r_acc <= w_acc;
        r_i1  <= w_i1n;
        r_i2  <= w_i2n;
      end else begin
        r_acc <= w_sum[WIDTH-1:0];
        r_i1  <= w_i1;
        r_i2  <= w_i2;
      end
      r_y <= y_step;
    end
  end

  assign y = r_y;

endmodule

// File: rtl/ds_dac_multi.sv
// Multi-channel delta-sigma DAC: rate divider, shadowed write port, per-channel modulators.
module ds_dac_multi
  import ds_dac_pkg::*;
#(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DIV_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                order_sel,
  input  logic [DIV_W-1:0]    rate_div,
  ds_dac_multi_if.slave       wr,
  output logic                sample_tick,
  output logic [CHANNELS-1:0] dac_out
);
  localparam int unsigned CHAN_W = clog2_min1(CHANNELS);

  logic [DIV_W-1:0]    r_cnt;
  logic                r_last_order;
  logic [WIDTH-1:0]    r_shadow [CHANNELS];
  logic [WIDTH-1:0]    r_active [CHANNELS];
  logic [CHANNELS-1:0] r_pending;
  logic [CHANNELS-1:0] r_dac;

  logic                w_tick;
  logic                w_clear;
  logic                w_ready;
  logic                w_accept;
  logic                w_pend_sel;
  logic [CHANNELS-1:0] w_sel;
  logic [CHANNELS-1:0] w_y;
  logic [CHANNELS-1:0] w_y_step;
  logic [CHANNELS-1:0] w_y_next;
  logic [WIDTH-1:0]    w_code [CHANNELS];

  assign w_tick      = enable && (r_cnt >= rate_div);
  assign w_clear     = w_tick && (order_sel != r_last_order);
  assign sample_tick = w_tick;
  assign dac_out     = r_dac;

  // Sample-rate divider; >= lets a lowered rate_div take effect immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else if (enable) r_cnt <= r_cnt + 1'b1;
    else             r_cnt <= '0;
  end

  // Remember the order in force so a change clears every channel at its first tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_last_order <= 1'b0;
    else if (w_tick) r_last_order <= order_sel;
  end

  // Channel decode for the write port; a tick frees a pending slot in the same cycle.
  always_comb begin
    w_sel      = '0;
    w_pend_sel = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (wr.in_chan == CHAN_W'(i)) begin
        w_sel[i]   = 1'b1;
        w_pend_sel = r_pending[i];
      end
    end
    w_ready     = !w_pend_sel || w_tick;
    w_accept    = wr.in_valid && w_ready;
    wr.in_ready = w_ready;
  end

  // Shadow/active registers: commit on tick, a same-cycle write re-arms pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (w_tick && r_pending[i]) begin
          r_active[i]  <= r_shadow[i];
          r_pending[i] <= 1'b0;
        end
        if (w_accept && w_sel[i]) begin
          r_shadow[i]  <= wr.in_data;
          r_pending[i] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign w_code[g]   = r_pending[g] ? r_shadow[g] : r_active[g];
    assign w_y_next[g] = w_tick ? w_y_step[g] : w_y[g];

    ds_mod_core #(
      .WIDTH(WIDTH)
    ) u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (w_tick),
      .clear (w_clear),
      .order (order_e'(order_sel)),
      .code  (w_code[g]),
      .y     (w_y[g]),
      .y_step(w_y_step[g])
    );
  end

  // Registered pulse outputs, forced low while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dac <= '0;
    else        r_dac <= enable ? w_y_next : '0;
  end

endmodule

// File: tb/tb_ds_dac_multi.sv
// Directed bench for ds_dac_multi with a behavioural reference model.
module tb_ds_dac_multi;
  localparam int WIDTH = 10;
  localparam int NCH   = 4;
  localparam int HALF  = 512;
  localparam int LIM   = 2048;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       order_sel = 1'b0;
  logic [7:0] rate_div = 8'd0;
  logic       sample_tick;
  logic [3:0] dac_out;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  ds_dac_multi_if #(.WIDTH(WIDTH), .CHANNELS(NCH)) wr ();

  ds_dac_multi #(.WIDTH(WIDTH), .CHANNELS(NCH), .DIV_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .order_sel  (order_sel),
    .rate_div   (rate_div),
    .wr         (wr),
    .sample_tick(sample_tick),
    .dac_out    (dac_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_cnt = 0;
  int m_shadow[NCH], m_active[NCH], m_acc[NCH], m_i1[NCH], m_i2[NCH];
  bit m_pend[NCH], m_y[NCH];
  bit m_last = 0;
  bit [3:0] m_dac = '0;

  function automatic int clamp(input int v);
    if (v > LIM) return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit tk, acc_ok;
    int ch_in, code, t, x, fb, n1, n2;
    if (!rst_n) begin
      m_cnt = 0; m_last = 0; m_dac = '0;
      for (int c = 0; c < NCH; c++) begin
        m_shadow[c] = 0; m_active[c] = 0; m_pend[c] = 0;
        m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_y[c] = 0;
      end
    end else begin
      tk     = enable && (m_cnt >= int'(rate_div));
      ch_in  = int'(wr.in_chan);
      acc_ok = wr.in_valid && (!m_pend[ch_in] || tk);
      if (tk) begin
        if (order_sel != m_last)
          for (int c = 0; c < NCH; c++) begin
            m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_y[c] = 0;
          end
        for (int c = 0; c < NCH; c++) begin
          code = m_pend[c] ? m_shadow[c] : m_active[c];
          if (!order_sel) begin
            t = m_acc[c] + code;
            m_y[c] = (t >= 1024);
            m_acc[c] = t % 1024;
          end else begin
            x  = code - HALF;
            fb = m_y[c] ? HALF : -HALF;
            n1 = clamp(m_i1[c] + x - fb);
            n2 = clamp(m_i2[c] + m_i1[c] - fb);
            m_i1[c] = n1; m_i2[c] = n2;
            m_y[c] = (n2 > 0);
          end
          if (m_pend[c]) begin m_active[c] = m_shadow[c]; m_pend[c] = 0; end
        end
        m_last = order_sel;
        m_cnt = 0;
      end else begin
        m_cnt = enable ? m_cnt + 1 : 0;
      end
      if (acc_ok) begin m_shadow[ch_in] = int'(wr.in_data); m_pend[ch_in] = 1; end
      for (int c = 0; c < NCH; c++) m_dac[c] = enable ? m_y[c] : 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      bit tk_exp;
      tk_exp = enable && (m_cnt >= int'(rate_div));
      chk("cyc_dac_out", dac_out, m_dac);
      chk("cyc_sample_tick", sample_tick, tk_exp);
      chk("cyc_in_ready", wr.in_ready, !m_pend[int'(wr.in_chan)] || tk_exp);
    end
  end

  // ---------------- stimulus helpers ----------------
  int ones[NCH], first_hi[NCH], last_hi[NCH];
  logic [31:0] pat[NCH];

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input int ch, input int val, output int waits);
    bit ok = 0;
    waits = 0;
    wr.in_valid = 1'b1; wr.in_chan = 2'(ch); wr.in_data = 10'(val);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (wr.in_ready) begin ok = 1; break; end
      waits++;
    end
    if (!ok) chk("write_accept_timeout", 0, 1);
    @(posedge clk); #1;
    wr.in_valid = 1'b0;
  endtask

  // Run n ticks (rate_div=0, enabled) and tally each channel's output.
  task automatic count_run(input int n);
    for (int c = 0; c < NCH; c++) begin
      ones[c] = 0; first_hi[c] = 0; last_hi[c] = 0; pat[c] = '0;
    end
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); @(negedge clk);
      for (int c = 0; c < NCH; c++)
        if (dac_out[c]) begin
          ones[c]++;
          if (first_hi[c] == 0) first_hi[c] = k;
          last_hi[c] = k;
          if (k <= 32) pat[c][k-1] = 1'b1;
        end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w2, nt, first_t, nz;
    bit found;
    wr.in_valid = 1'b0; wr.in_chan = '0; wr.in_data = '0;
    repeat (3) @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_dac_out", dac_out, 0);
    chk("reset_in_ready", wr.in_ready, 1);
    chk("reset_sample_tick", sample_tick, 0);
    sync(); rst_n = 1'b1;

    // T1: 1st order, ch0 code 256
    do_write(0, 256, w);
    enable = 1'b1;
    count_run(1024);
    chk("t1_ch0_ones", ones[0], 256);
    chk("t1_ch0_first_high_tick", first_hi[0], 4);
    chk("t1_ch1_code0_ones", ones[1], 0);

    // T4: all channels concurrently, 1st order, including full-scale and zero codes
    sync(); enable = 1'b0;
    do_write(0, 1023, w); do_write(1, 0, w); do_write(2, 300, w); do_write(3, 700, w);
    enable = 1'b1;
    count_run(1024);
    chk("t4_ch0_ones_1023", ones[0], 1023);
    chk("t4_ch1_ones_0", ones[1], 0);
    chk("t4_ch2_ones_300", ones[2], 300);
    chk("t4_ch3_ones_700", ones[3], 700);

    // T2: 2nd order, ch2 mid-scale then zero
    sync(); enable = 1'b0;
    do_write(2, 512, w);
    order_sel = 1'b1; enable = 1'b1;
    count_run(1024);
    chk("t2_ch2_ones_512_pm2", (ones[2] >= 510 && ones[2] <= 514), 1);
    chk("t2_ch2_first_high_tick", first_hi[2], 1);
    do_write(2, 0, w);
    count_run(4096);
    chk("t2_ch2_code0_settled", (last_hi[2] < 64), 1);

    // T3: rate_div=9, back-to-back writes to ch1 inside one tick period
    sync(); order_sel = 1'b0; rate_div = 8'd9;
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (sample_tick) begin found = 1; break; end
    end
    chk("t3_tick_seen", found, 1);
    sync();
    do_write(1, 100, w);
    do_write(1, 200, w2);
    chk("t3_first_write_waits", w, 0);
    chk("t3_second_write_waits", w2, 8);
    nt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sample_tick) nt++;
    end
    chk("t3_ticks_per_100_clocks", nt, 10);

    // T5: enable drop / resume, then order toggles
    sync(); rate_div = 8'd0;
    do_write(0, 256, w); do_write(1, 1023, w); do_write(2, 512, w);
    count_run(64);
    sync(); enable = 1'b0;
    @(negedge clk); chk("t5_no_tick_when_disabled", sample_tick, 0);
    @(negedge clk); chk("t5_dac_zero_when_disabled", dac_out, 0);
    repeat (4) @(negedge clk);
    sync(); enable = 1'b1;
    count_run(1024);
    chk("t5_resume_ch0_ones", ones[0], 256);
    chk("t5_resume_ch1_ones", ones[1], 1023);
    sync(); order_sel = 1'b1;
    count_run(8);
    chk("t5_order2_clear_ch2_pattern", pat[2][7:0], 8'b0011_0011);
    sync(); order_sel = 1'b0;
    count_run(8);
    chk("t5_order1_clear_ch0_pattern", pat[0][7:0], 8'b1000_1000);

    // T6: asynchronous reset between edges
    sync(); rate_div = 8'd3;
    repeat (6) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_dac_out", dac_out, 0);
    chk("t6_async_in_ready", wr.in_ready, 1);
    chk("t6_async_sample_tick", sample_tick, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    first_t = 0; nz = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (sample_tick && first_t == 0) first_t = k;
      if (dac_out != 4'd0) nz++;
      if (k == 1) chk("t6_ready_after_release", wr.in_ready, 1);
    end
    chk("t6_first_tick_cycle", first_t, 3);
    chk("t6_outputs_idle", nz, 0);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
